// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the memory-bus arbiter slice.
//   - Default bus widths used as parameter defaults by bus_arbiter.
//   - bus_req_t: request record (id, address, data, write) at the default
//     widths, for blocks that use the default bus.
//   - bus_idx_w(): index width needed to name one of n ports.
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam int BUS_NUM_MASTERS = 4;
    localparam int BUS_DATA_WIDTH  = 24;
    localparam int BUS_ADDR_WIDTH  = 32;
    localparam int BUS_ID_WIDTH    = 8;

    typedef struct packed {
        logic [BUS_ID_WIDTH-1:0]   id;
        logic [BUS_ADDR_WIDTH-1:0] address;
        logic [BUS_DATA_WIDTH-1:0] data;
        logic                      write;
    } bus_req_t;

    // At least one bit, even for a single port.
    function automatic int bus_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Chooses one requester out of NUM_MASTERS.
//   Default: round-robin, search starts one past `last` and wraps.
//   BUS_ARBITER_FIXED_PRIORITY_EN defined: lowest-index requester wins and
//   the `last` port does not exist.
// Ports:
//   req    in   NUM_MASTERS  request vector
//   last   in   IDX_W        most recently granted index (round-robin only)
//   grant  out  NUM_MASTERS  one-hot grant (all zero when no request)
//   idx    out  IDX_W        index of granted port
//   any    out  1            some request was granted
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
`ifndef BUS_ARBITER_FIXED_PRIORITY_EN
    input  logic [IDX_W-1:0]       last,
`endif
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       idx,
    output logic                   any
);

`ifdef BUS_ARBITER_FIXED_PRIORITY_EN
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!any && req[i]) begin
                any      = 1'b1;
                idx      = IDX_W'(i);
                grant[i] = 1'b1;
            end
        end
    end
`else
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // Visit last+1, last+2, ... wrapping, so `last` itself is checked last.
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            j = (int'(last) + off) % NUM_MASTERS;
            if (!any && req[j]) begin
                any      = 1'b1;
                idx      = IDX_W'(j);
                grant[j] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Merges NUM_MASTERS memory-bus masters onto one downstream slave port.
// Requests are arbitrated (round-robin by default) into a one-entry output
// register; responses are routed back combinationally by ID.
// Build option: BUS_ARBITER_FIXED_PRIORITY_EN selects fixed priority
// (lowest index wins) instead of round-robin.
// Ports:
//   clock, reset                  clock, asynchronous active-high reset
//   mMsID/Address/Data/Write/Valid  in   per-port requests
//   mMsTaken                      out  per-port request accepted this cycle
//   mSmID/mSmData                 out  response broadcast to every port
//   mSmValid                      out  response valid for port i (ID match)
//   mSmTaken                      in   per-port response accept
//   msID/Address/Data/Write/Valid out  downstream request (registered)
//   msTaken                       in   downstream accepts request
//   smID/smData/smValid           in   downstream response
//   smTaken                       out  response consumed (1 for unknown IDs)
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS     = BUS_NUM_MASTERS,
    parameter int DATA_WIDTH      = BUS_DATA_WIDTH,
    parameter int ADDRESS_WIDTH   = BUS_ADDR_WIDTH,
    parameter int MASTER_ID_WIDTH = BUS_ID_WIDTH,
    parameter logic [NUM_MASTERS*MASTER_ID_WIDTH-1:0] PORT_IDS = {8'd3, 8'd2, 8'd1, 8'd0}
) (
    input  logic                       clock,
    input  logic                       reset,

    input  logic [MASTER_ID_WIDTH-1:0] mMsID      [NUM_MASTERS-1:0],
    input  logic [ADDRESS_WIDTH-1:0]   mMsAddress [NUM_MASTERS-1:0],
    input  logic [DATA_WIDTH-1:0]      mMsData    [NUM_MASTERS-1:0],
    input  logic                       mMsWrite   [NUM_MASTERS-1:0],
    input  logic                       mMsValid   [NUM_MASTERS-1:0],
    output logic                       mMsTaken   [NUM_MASTERS-1:0],

    output logic [MASTER_ID_WIDTH-1:0] mSmID      [NUM_MASTERS-1:0],
    output logic [DATA_WIDTH-1:0]      mSmData    [NUM_MASTERS-1:0],
    output logic                       mSmValid   [NUM_MASTERS-1:0],
    input  logic                       mSmTaken   [NUM_MASTERS-1:0],

    output logic [MASTER_ID_WIDTH-1:0] msID,
    output logic [ADDRESS_WIDTH-1:0]   msAddress,
    output logic [DATA_WIDTH-1:0]      msData,
    output logic                       msWrite,
    output logic                       msValid,
    input  logic                       msTaken,

    input  logic [MASTER_ID_WIDTH-1:0] smID,
    input  logic [DATA_WIDTH-1:0]      smData,
    input  logic                       smValid,
    output logic                       smTaken
);

    localparam int IDX_W = bus_idx_w(NUM_MASTERS);

    // Request record at this instance's widths.
    typedef struct packed {
        logic [MASTER_ID_WIDTH-1:0] id;
        logic [ADDRESS_WIDTH-1:0]   address;
        logic [DATA_WIDTH-1:0]      data;
        logic                       write;
    } req_t;

    logic [NUM_MASTERS-1:0] req_vec;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       gidx;
    logic                   gany;
    logic                   free;
    req_t                   nxt_req;
    req_t                   req_p0;
    logic                   vld_p0;
`ifndef BUS_ARBITER_FIXED_PRIORITY_EN
    logic [IDX_W-1:0]       lastGrant;
`endif

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            req_vec[i] = mMsValid[i];
        end
    end

    rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req   (req_vec),
`ifndef BUS_ARBITER_FIXED_PRIORITY_EN
        .last  (lastGrant),
`endif
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    // The register can accept a new request when empty or draining this cycle.
    assign free = !vld_p0 || msTaken;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            mMsTaken[i] = free && grant[i];
        end
        nxt_req.id      = mMsID[gidx];
        nxt_req.address = mMsAddress[gidx];
        nxt_req.data    = mMsData[gidx];
        nxt_req.write   = mMsWrite[gidx];
    end

    // Stage p0: downstream request register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p0    <= 1'b0;
            req_p0    <= '0;
`ifndef BUS_ARBITER_FIXED_PRIORITY_EN
            lastGrant <= IDX_W'(NUM_MASTERS - 1);
`endif
        end else if (free) begin
            vld_p0 <= gany;
            if (gany) begin
                req_p0    <= nxt_req;
`ifndef BUS_ARBITER_FIXED_PRIORITY_EN
                lastGrant <= gidx;
`endif
            end
        end
    end

    assign msValid   = vld_p0;
    assign msID      = req_p0.id;
    assign msAddress = req_p0.address;
    assign msData    = req_p0.data;
    assign msWrite   = req_p0.write;

    // Response routing: broadcast payload, per-port valid by ID match.
    // smTaken comes from the lowest matching port; an unknown ID is
    // swallowed so a stray response can never stall the bus.
    always_comb begin
        logic hit;
        hit     = 1'b0;
        smTaken = 1'b1;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            mSmID[i]    = smID;
            mSmData[i]  = smData;
            mSmValid[i] = smValid && (smID == PORT_IDS[i*MASTER_ID_WIDTH +: MASTER_ID_WIDTH]);
            if (!hit && (smID == PORT_IDS[i*MASTER_ID_WIDTH +: MASTER_ID_WIDTH])) begin
                hit     = 1'b1;
                smTaken = mSmTaken[i];
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter: table of response-routing vectors plus
// hand-written request-path sequences (single request, fairness,
// backpressure, reset mid-transfer).
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int DW = 24;
    localparam int AW = 32;
    localparam int IW = 8;

    logic          clock = 1'b0;
    logic          reset;

    logic [IW-1:0] mMsID      [N-1:0];
    logic [AW-1:0] mMsAddress [N-1:0];
    logic [DW-1:0] mMsData    [N-1:0];
    logic          mMsWrite   [N-1:0];
    logic          mMsValid   [N-1:0];
    logic          mMsTaken   [N-1:0];
    logic [IW-1:0] mSmID      [N-1:0];
    logic [DW-1:0] mSmData    [N-1:0];
    logic          mSmValid   [N-1:0];
    logic          mSmTaken   [N-1:0];

    logic [IW-1:0] msID;
    logic [AW-1:0] msAddress;
    logic [DW-1:0] msData;
    logic          msWrite;
    logic          msValid;
    logic          msTaken;
    logic [IW-1:0] smID;
    logic [DW-1:0] smData;
    logic          smValid;
    logic          smTaken;

    int n_checks;
    int n_fail;

    logic [N-1:0] taken_v;
    logic [N-1:0] smv_v;

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            taken_v[i] = mMsTaken[i];
            smv_v[i]   = mSmValid[i];
        end
    end

    bus_arbiter #(
        .NUM_MASTERS     (N),
        .DATA_WIDTH      (DW),
        .ADDRESS_WIDTH   (AW),
        .MASTER_ID_WIDTH (IW),
        .PORT_IDS        ({8'd3, 8'd2, 8'd1, 8'd0})
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mMsID      (mMsID),
        .mMsAddress (mMsAddress),
        .mMsData    (mMsData),
        .mMsWrite   (mMsWrite),
        .mMsValid   (mMsValid),
        .mMsTaken   (mMsTaken),
        .mSmID      (mSmID),
        .mSmData    (mSmData),
        .mSmValid   (mSmValid),
        .mSmTaken   (mSmTaken),
        .msID       (msID),
        .msAddress  (msAddress),
        .msData     (msData),
        .msWrite    (msWrite),
        .msValid    (msValid),
        .msTaken    (msTaken),
        .smID       (smID),
        .smData     (smData),
        .smValid    (smValid),
        .smTaken    (smTaken)
    );

    typedef struct packed {
        logic          v;
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [N-1:0]  tk;
        logic [N-1:0]  exp_v;
        logic          exp_tk;
    } rsp_vec_t;

    rsp_vec_t rtab [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            mMsID[i]      = IW'(i);
            mMsAddress[i] = '0;
            mMsData[i]    = '0;
            mMsWrite[i]   = 1'b0;
            mMsValid[i]   = 1'b0;
            mSmTaken[i]   = 1'b0;
        end
        msTaken = 1'b0;
        smID    = '0;
        smData  = '0;
        smValid = 1'b0;
    endtask

    // Leaves the bench at posedge+1 with reset released.
    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] exp_g;
        n_checks = 0;
        n_fail   = 0;

        rtab[0] = '{1'b1, 8'h03, 24'h123456, 4'b0000, 4'b1000, 1'b0};
        rtab[1] = '{1'b1, 8'h03, 24'h123456, 4'b1000, 4'b1000, 1'b1};
        rtab[2] = '{1'b1, 8'h03, 24'h123456, 4'b0111, 4'b1000, 1'b0};
        rtab[3] = '{1'b1, 8'h55, 24'h0F0F0F, 4'b0000, 4'b0000, 1'b1};
        rtab[4] = '{1'b0, 8'h01, 24'h777777, 4'b0010, 4'b0000, 1'b1};
        rtab[5] = '{1'b1, 8'h00, 24'hA5A5A5, 4'b0001, 4'b0001, 1'b1};
        rtab[6] = '{1'b1, 8'h02, 24'h000001, 4'b1011, 4'b0100, 1'b0};

        // Reset state
        reset = 1'b1;
        clear_inputs();
        #2;
        check("rst_msValid",   64'(msValid),   64'd0);
        check("rst_msID",      64'(msID),      64'd0);
        check("rst_msAddress", 64'(msAddress), 64'd0);
        check("rst_msData",    64'(msData),    64'd0);
        check("rst_msWrite",   64'(msWrite),   64'd0);
        check("rst_mMsTaken",  64'(taken_v),   64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Single request from port 2
        mMsValid[2]   = 1'b1;
        mMsID[2]      = 8'd2;
        mMsAddress[2] = 32'h100;
        mMsData[2]    = 24'hABCDEF;
        mMsWrite[2]   = 1'b1;
        msTaken       = 1'b1;
        #1 check("single_grant", 64'(taken_v), 64'b0100);
        @(posedge clock); #1;
        mMsValid[2] = 1'b0;
        #1;
        check("single_msValid", 64'(msValid),   64'd1);
        check("single_msID",    64'(msID),      64'd2);
        check("single_msAddr",  64'(msAddress), 64'h100);
        check("single_msData",  64'(msData),    64'hABCDEF);
        check("single_msWrite", 64'(msWrite),   64'd1);
        check("single_no_more", 64'(taken_v),   64'd0);
        @(posedge clock); #2;
        check("single_drained", 64'(msValid),   64'd0);

        // Fairness with all ports requesting
        do_reset();
        for (int i = 0; i < N; i++) begin
            mMsValid[i]   = 1'b1;
            mMsAddress[i] = 32'h1000 + 32'(i);
        end
        msTaken = 1'b1;
        for (int k = 0; k < 6; k++) begin
`ifdef BUS_ARBITER_FIXED_PRIORITY_EN
            exp_g = 4'b0001;
`else
            exp_g = 4'(1 << (k % N));
`endif
            #1 check($sformatf("fair_grant_%0d", k), 64'(taken_v), 64'(exp_g));
            if (k > 0) begin
`ifdef BUS_ARBITER_FIXED_PRIORITY_EN
                check($sformatf("fair_msID_%0d", k), 64'(msID), 64'd0);
`else
                check($sformatf("fair_msID_%0d", k), 64'(msID), 64'((k - 1) % N));
`endif
            end
            @(posedge clock); #1;
        end

        // Backpressure with ports 1 and 3 requesting
        do_reset();
        mMsValid[1]   = 1'b1;
        mMsAddress[1] = 32'h0000_0111;
        mMsValid[3]   = 1'b1;
        mMsAddress[3] = 32'h0000_0333;
        msTaken       = 1'b0;
        #1 check("bp_first_grant", 64'(taken_v), 64'b0010);
        @(posedge clock); #1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp_taken_%0d", c), 64'(taken_v),   64'd0);
            check($sformatf("bp_valid_%0d", c), 64'(msValid),   64'd1);
            check($sformatf("bp_id_%0d", c),    64'(msID),      64'd1);
            check($sformatf("bp_addr_%0d", c),  64'(msAddress), 64'h111);
            @(posedge clock); #1;
        end
        msTaken = 1'b1;
        #1;
`ifdef BUS_ARBITER_FIXED_PRIORITY_EN
        check("bp_release_grant", 64'(taken_v), 64'b0010);
        @(posedge clock); #1;
        check("bp_next_id", 64'(msID), 64'd1);
`else
        check("bp_release_grant", 64'(taken_v), 64'b1000);
        @(posedge clock); #1;
        check("bp_next_id", 64'(msID), 64'd3);
`endif
        check("bp_next_valid", 64'(msValid), 64'd1);

        // Response routing table
        do_reset();
        for (int t = 0; t < 7; t++) begin
            smValid = rtab[t].v;
            smID    = rtab[t].id;
            smData  = rtab[t].data;
            for (int i = 0; i < N; i++) mSmTaken[i] = rtab[t].tk[i];
            #1;
            check($sformatf("rsp_valid_%0d", t), 64'(smv_v),      64'(rtab[t].exp_v));
            check($sformatf("rsp_taken_%0d", t), 64'(smTaken),    64'(rtab[t].exp_tk));
            check($sformatf("rsp_data_%0d", t),  64'(mSmData[3]), 64'(rtab[t].data));
            check($sformatf("rsp_id_%0d", t),    64'(mSmID[1]),   64'(rtab[t].id));
        end
        clear_inputs();

        // Reset while a request is held under backpressure
        do_reset();
        mMsValid[2]   = 1'b1;
        mMsAddress[2] = 32'h200;
        msTaken       = 1'b0;
        #1 check("rm_grant", 64'(taken_v), 64'b0100);
        @(posedge clock); #1;
        mMsValid[2] = 1'b0;
        #1 check("rm_held", 64'(msValid), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rm_async_valid", 64'(msValid), 64'd0);
        check("rm_async_id",    64'(msID),    64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < N; i++) mMsValid[i] = 1'b1;
        msTaken = 1'b1;
        #1 check("rm_first_grant", 64'(taken_v), 64'b0001);
        @(posedge clock); #1;
        check("rm_first_id",    64'(msID),    64'd0);
        check("rm_first_valid", 64'(msValid), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
